// File: rtl/pid_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : pid_pipe_param
// Purpose  : Parametrised, pipelined PID steering controller. Turns a signed
//            heading error and a forward speed into clamped left/right motor
//            speeds. It has programmable P/D gains, a clamping integrator and
//            registered outputs with a one-cycle valid strobe. It accepts one
//            sample per clock, and outputs appear two edges after capture.
// Options  : PID_DEADBAND_EN - when defined, errors with |err| < DEADBAND
//            contribute nothing to P or to the integrator.
// Revision : 1.0 - initial release
// ============================================================================
module pid_pipe_param #(
  parameter int ERR_W     = 12,
  parameter int SAT_W     = 10,
  parameter int D_SAT_W   = 7,
  parameter int INT_W     = 15,
  parameter int I_SHIFT   = 6,
  parameter int CW        = 6,
  parameter int OUT_SHIFT = 3,
  parameter int SPD_W     = 11,
  parameter int DEADBAND  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             moving,
  input  logic             err_vld,
  input  logic [ERR_W-1:0] error,
  input  logic [SPD_W-2:0] frwrd,
  input  logic [CW-1:0]    p_coeff,
  input  logic [CW-1:0]    d_coeff,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             spd_vld
);

  localparam int c_DD_W  = SAT_W + 1;
  localparam int c_P_W   = SAT_W + CW + 1;
  localparam int c_D_W   = D_SAT_W + CW + 1;
  localparam int c_IS_W  = INT_W + 1;
  localparam int c_PID_W = SAT_W + CW + 2;
  localparam int c_MIX_W = ((c_PID_W > SPD_W) ? c_PID_W : SPD_W) + 1;

  localparam logic signed [ERR_W-1:0]   c_ERR_HI = ERR_W'((2 ** (SAT_W - 1)) - 1);
  localparam logic signed [ERR_W-1:0]   c_ERR_LO = -ERR_W'(2 ** (SAT_W - 1));
  localparam logic signed [c_DD_W-1:0]  c_D_HI   = c_DD_W'((2 ** (D_SAT_W - 1)) - 1);
  localparam logic signed [c_DD_W-1:0]  c_D_LO   = -c_DD_W'(2 ** (D_SAT_W - 1));
  localparam logic signed [c_IS_W-1:0]  c_INT_HI = c_IS_W'((2 ** (INT_W - 1)) - 1);
  localparam logic signed [c_IS_W-1:0]  c_INT_LO = -c_IS_W'(2 ** (INT_W - 1));
  localparam logic signed [c_MIX_W-1:0] c_SPD_HI = c_MIX_W'((2 ** (SPD_W - 1)) - 1);
  localparam logic signed [c_DD_W-1:0]  c_DB     = c_DD_W'(DEADBAND);

`ifdef PID_DEADBAND_EN
  localparam bit c_DB_EN = 1'b1;
`else
  localparam bit c_DB_EN = 1'b0;
`endif

  // Stage-1 state
  logic signed [SAT_W-1:0]   r_hist0;
  logic signed [SAT_W-1:0]   r_hist1;
  logic signed [INT_W-1:0]   r_int;
  logic signed [c_P_W-1:0]   r_p;
  logic signed [c_D_W-1:0]   r_d;
  logic        [SPD_W-2:0]   r_frwrd1;
  logic                      r_v1;
  // Stage-2 state
  logic signed [c_PID_W-1:0] r_pid;
  logic        [SPD_W-2:0]   r_frwrd2;
  logic                      r_v2;

  logic signed [ERR_W-1:0]   w_err_in;
  logic signed [SAT_W-1:0]   w_err_sat;
  logic signed [c_DD_W-1:0]  w_err_ext;
  logic                      w_in_db;
  logic signed [SAT_W-1:0]   w_err_pi;
  logic signed [c_DD_W-1:0]  w_d_diff;
  logic signed [D_SAT_W-1:0] w_d_sat;
  logic signed [c_P_W-1:0]   w_p;
  logic signed [c_D_W-1:0]   w_d;
  logic signed [c_IS_W-1:0]  w_int_sum;
  logic signed [INT_W-1:0]   w_int_nxt;
  logic signed [INT_W-1:0]   w_iterm;
  logic signed [c_PID_W-1:0] w_pid;
  logic signed [c_PID_W-1:0] w_s;
  logic signed [c_MIX_W-1:0] w_lft;
  logic signed [c_MIX_W-1:0] w_rght;

  assign w_err_in = $signed(error);

  // Saturate the raw error to the controller's working width
  always_comb begin
    w_err_sat = SAT_W'(w_err_in);
    if (w_err_in > c_ERR_HI) begin
      w_err_sat = SAT_W'(c_ERR_HI);
    end else if (w_err_in < c_ERR_LO) begin
      w_err_sat = SAT_W'(c_ERR_LO);
    end
  end

  // Deadband only gates P and the integrator; D always sees the real error
  assign w_err_ext = c_DD_W'(w_err_sat);
  assign w_in_db   = c_DB_EN && (w_err_ext < c_DB) && (w_err_ext > -c_DB);
  assign w_err_pi  = w_in_db ? '0 : w_err_sat;

  // Difference against the sample two valids back, saturated before the gain
  assign w_d_diff = c_DD_W'(w_err_sat) - c_DD_W'(r_hist1);
  always_comb begin
    w_d_sat = D_SAT_W'(w_d_diff);
    if (w_d_diff > c_D_HI) begin
      w_d_sat = D_SAT_W'(c_D_HI);
    end else if (w_d_diff < c_D_LO) begin
      w_d_sat = D_SAT_W'(c_D_LO);
    end
  end

  // Gains are unsigned; a zero sign bit makes them safe signed operands
  assign w_p = c_P_W'(w_err_pi) * c_P_W'($signed({1'b0, p_coeff}));
  assign w_d = c_D_W'(w_d_sat) * c_D_W'($signed({1'b0, d_coeff}));

  // Integrator clamps at its rails rather than wrapping or freezing
  assign w_int_sum = c_IS_W'(r_int) + c_IS_W'(w_err_pi);
  always_comb begin
    w_int_nxt = INT_W'(w_int_sum);
    if (w_int_sum > c_INT_HI) begin
      w_int_nxt = INT_W'(c_INT_HI);
    end else if (w_int_sum < c_INT_LO) begin
      w_int_nxt = INT_W'(c_INT_LO);
    end
  end

  // Error history shifts on every valid sample, independent of moving
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist0 <= '0;
      r_hist1 <= '0;
    end else if (err_vld) begin
      r_hist1 <= r_hist0;
      r_hist0 <= w_err_sat;
    end
  end

  // Integrator accumulates only while moving; stopping clears it
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      r_int <= '0;
    end else if (err_vld) begin
      r_int <= w_int_nxt;
    end
  end

  // Stage 1 capture of P, D and forward speed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p      <= '0;
      r_d      <= '0;
      r_frwrd1 <= '0;
    end else if (err_vld) begin
      r_p      <= w_p;
      r_d      <= w_d;
      r_frwrd1 <= frwrd;
    end
  end

  // Stage 2 sum; r_int already holds the post-update value of this sample
  assign w_iterm = r_int >>> I_SHIFT;
  assign w_pid   = c_PID_W'(r_p) + c_PID_W'(r_d) + c_PID_W'(w_iterm);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pid    <= '0;
      r_frwrd2 <= '0;
    end else if (r_v1) begin
      r_pid    <= w_pid;
      r_frwrd2 <= r_frwrd1;
    end
  end

  // Pipeline valids; dropping moving flushes anything in flight
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= err_vld;
      r_v2 <= r_v1;
    end
  end

  // Output mixing: floor-shifted steer term added to / removed from forward
  assign w_s    = r_pid >>> OUT_SHIFT;
  assign w_lft  = c_MIX_W'($signed({1'b0, r_frwrd2})) + c_MIX_W'(w_s);
  assign w_rght = c_MIX_W'($signed({1'b0, r_frwrd2})) - c_MIX_W'(w_s);

  function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [c_MIX_W-1:0] v);
    logic [SPD_W-1:0] r;
    r = SPD_W'(v);
    if (v < 0) begin
      r = '0;
    end else if (v > c_SPD_HI) begin
      r = SPD_W'(c_SPD_HI);
    end
    return r;
  endfunction

  // Registered outputs: update on a valid result, hold otherwise
  always_ff @(posedge clk) begin
    if (rst || !moving) begin
      lft_spd  <= '0;
      rght_spd <= '0;
      spd_vld  <= 1'b0;
    end else begin
      spd_vld <= r_v2;
      if (r_v2) begin
        lft_spd  <= clamp_spd(w_lft);
        rght_spd <= clamp_spd(w_rght);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_pipe_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pid_pipe_param
// Purpose  : Scoreboard bench for pid_pipe_param. The driver queues the
//            expected speeds for each sample, and a monitor pops and compares
//            them whenever spd_vld is high.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_pipe_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        moving;
  logic        err_vld;
  logic [11:0] error;
  logic [9:0]  frwrd;
  logic [5:0]  p_coeff;
  logic [5:0]  d_coeff;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        spd_vld;

  int n_checks = 0;
  int n_errors = 0;
  int run_len  = 0;
  int max_run  = 0;
  bit mon_en   = 1'b0;
  logic [21:0] exp_q[$];

  pid_pipe_param dut (
    .clk      (clk),
    .rst      (rst),
    .moving   (moving),
    .err_vld  (err_vld),
    .error    (error),
    .frwrd    (frwrd),
    .p_coeff  (p_coeff),
    .d_coeff  (d_coeff),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .spd_vld  (spd_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each strobe against the oldest expected result
  always @(negedge clk) begin
    if (mon_en) begin
      if (spd_vld !== 1'b0) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_strobe: spd_vld=%b with no expected sample at %0t", spd_vld, $time);
        end else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          check("lft_spd", {21'd0, lft_spd}, {21'd0, e[21:11]});
          check("rght_spd", {21'd0, rght_spd}, {21'd0, e[10:0]});
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic send(input int e, input int l, input int r, input bit expect_out);
    logic [31:0] ev;
    logic [31:0] lv;
    logic [31:0] rv;
    ev = e;
    lv = l;
    rv = r;
    @(negedge clk);
    err_vld = 1'b1;
    error   = ev[11:0];
    if (expect_out) exp_q.push_back({lv[10:0], rv[10:0]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      err_vld = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      err_vld = 1'b0;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Reset is held against active inputs to show it dominates
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; moving = 1'b1; err_vld = 1'b1; error = 12'h100;
    @(negedge clk);
    @(negedge clk);
    check("rst_lft", {21'd0, lft_spd}, 32'd0);
    check("rst_rght", {21'd0, rght_spd}, 32'd0);
    check("rst_vld", {31'd0, spd_vld}, 32'd0);
    rst = 1'b0; err_vld = 1'b0; error = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; moving = 1'b0; err_vld = 1'b0; error = '0;
    frwrd = '0; p_coeff = '0; d_coeff = '0;

    // Basic proportional response and latency
    do_reset();
    mon_en = 1'b1;
    p_coeff = 6'd8; d_coeff = 6'd0; frwrd = 10'h100;
    send(12'h010, 12'h110, 12'h0F0, 1'b1);
    @(negedge clk); err_vld = 1'b0;
    check("lat_n1", {31'd0, spd_vld}, 32'd0);
    @(negedge clk);
    check("lat_n2", {31'd0, spd_vld}, 32'd0);
    @(negedge clk);
    check("lat_n3", {31'd0, spd_vld}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("hold_lft", {21'd0, lft_spd}, 32'h110);
    check("hold_rght", {21'd0, rght_spd}, 32'h0F0);
    drain();

    // Positive saturation of error and D, left clamps high
    do_reset();
    p_coeff = 6'd8; d_coeff = 6'd11; frwrd = 10'h3FF;
    send(12'h7FF, 12'h3FF, 12'h1A9, 1'b1);
    idle(1);
    drain();

    // Negative saturation, left clamps at zero
    do_reset();
    p_coeff = 6'd8; d_coeff = 6'd0; frwrd = 10'h010;
    send(12'h800, 12'h000, 12'h211, 1'b1);
    idle(1);
    drain();

    // Integrator wind-up clamps at its positive rail
    do_reset();
    p_coeff = 6'd0; d_coeff = 6'd0; frwrd = 10'h100;
    for (int k = 1; k <= 40; k++) begin
      int integ;
      int s;
      integ = 511 * k;
      if (integ > 16383) integ = 16383;
      s = (integ / 64) / 8;
      send(12'h1FF, 256 + s, 256 - s, 1'b1);
    end
    idle(1);
    drain();
    check("windup_lft", {21'd0, lft_spd}, 32'h11F);
    check("windup_rght", {21'd0, rght_spd}, 32'h0E1);

    // Dropping moving flushes the pipeline and clears the integrator
    do_reset();
    p_coeff = 6'd0; d_coeff = 6'd0; frwrd = 10'h100;
    send(12'h1FF, 256, 256, 1'b1);
    send(12'h1FF, 257, 255, 1'b1);
    send(12'h1FF, 258, 254, 1'b1);
    send(12'h1FF, 259, 253, 1'b1);
    idle(3);
    drain();
    send(12'h1FF, 0, 0, 1'b0);
    @(negedge clk); err_vld = 1'b0; moving = 1'b0;
    @(negedge clk);
    check("stop_lft", {21'd0, lft_spd}, 32'd0);
    check("stop_rght", {21'd0, rght_spd}, 32'd0);
    check("stop_vld", {31'd0, spd_vld}, 32'd0);
    moving = 1'b1;
    @(negedge clk);
    check("flush_vld", {31'd0, spd_vld}, 32'd0);
    send(12'h040, 256, 256, 1'b1);
    idle(1);
    drain();

    // Eight back-to-back samples exercising P, D history and floor shift
    do_reset();
    p_coeff = 6'd4; d_coeff = 6'd2; frwrd = 10'h200;
    max_run = 0;
    send(10,   519, 505, 1'b1);
    send(20,   527, 497, 1'b1);
    send(30,   532, 492, 1'b1);
    send(40,   537, 487, 1'b1);
    send(-10,  497, 527, 1'b1);
    send(-20,  487, 537, 1'b1);
    send(100,  578, 446, 1'b1);
    send(0,    517, 507, 1'b1);
    idle(1);
    drain();
    check("b2b_run", max_run, 8);

    // Gain change applies only to samples captured after it
    do_reset();
    p_coeff = 6'd8; d_coeff = 6'd0; frwrd = 10'h100;
    send(12'h010, 12'h110, 12'h0F0, 1'b1);
    @(negedge clk);
    p_coeff = 6'd2; error = 12'h010; err_vld = 1'b1;
    exp_q.push_back({11'd260, 11'd252});
    idle(1);
    drain();

    // Small error: zeroed by the deadband when it is enabled
    do_reset();
    p_coeff = 6'd8; d_coeff = 6'd0; frwrd = 10'h100;
`ifdef PID_DEADBAND_EN
    send(3, 256, 256, 1'b1);
    send(0, 256, 256, 1'b1);
`else
    send(3, 259, 253, 1'b1);
    send(0, 256, 256, 1'b1);
`endif
    idle(1);
    drain();

    idle(3);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
